// File: rtl/warp_arb_pkg.sv
// Shared types and sizing helpers for the warp datapath arbiter and its
// round-robin picker.
package warp_arb_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_NUM_WARPS = 2;
  localparam int DEFAULT_MAX_HOLD  = 64;

  function automatic int warp_idx_bits(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  // One extra bit so MAX_HOLD-1 always fits, including power-of-two MAX_HOLD.
  function automatic int hold_cnt_bits(input int max_hold);
    return $clog2(max_hold) + 1;
  endfunction

  localparam int WARP_IDX_BITS = warp_idx_bits(DEFAULT_NUM_WARPS);
  localparam int HOLD_CNT_BITS = hold_cnt_bits(DEFAULT_MAX_HOLD);

endpackage

// File: rtl/warp_arbiter_rr_picker.sv
// Combinational rotating-priority picker: the first set request at or above
// ptr_i wins, otherwise the lowest set request below ptr_i wins.
module rr_picker
  import warp_arb_pkg::*;
#(
  parameter int N    = DEFAULT_NUM_WARPS,
  parameter int IDXW = warp_idx_bits(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic            found_o
);

  logic [N-1:0] gnt;
  logic         found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int w = 0; w < N; w++) begin
      if (!found && req_i[w] && (w >= int'(ptr_i))) begin
        gnt[w] = 1'b1;
        found  = 1'b1;
      end
    end
    // Wrap-around pass only sees requests below ptr_i.
    for (int w = 0; w < N; w++) begin
      if (!found && req_i[w]) begin
        gnt[w] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign gnt_o   = gnt;
  assign found_o = found;

endmodule

// File: rtl/warp_arbiter.sv
// Round-robin owner of the shared decoder/ALU/PC datapath: one warp per
// instruction, hold-time watchdog, and core-level done aggregation.
module warp_arbiter
  import warp_arb_pkg::*;
#(
  parameter int NUM_WARPS = DEFAULT_NUM_WARPS,
  parameter int MAX_HOLD  = DEFAULT_MAX_HOLD
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_WARPS-1:0]         start_i,
  input  logic [NUM_WARPS-1:0]         warp_done_i,
  input  logic [NUM_WARPS-1:0]         issue_req_i,
  input  logic [NUM_WARPS-1:0]         release_i,
  output logic [NUM_WARPS-1:0]         grant_o,
  output logic                         grant_valid_o,
  output logic [$clog2(NUM_WARPS)-1:0] warp_select_o,
  output logic                         done_o,
  output logic                         hold_error_o
);

  localparam int IDXW = warp_idx_bits(NUM_WARPS);
  localparam int HCW  = hold_cnt_bits(MAX_HOLD);

  arb_state_t           state_q, state_d;
  logic [NUM_WARPS-1:0] active_q, active_d;
  logic [NUM_WARPS-1:0] grant_q, grant_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]      sel_q, sel_d;
  logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                 hold_err_q, hold_err_d;
  logic                 started_q, started_d;
  logic                 done_q, done_d;

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] pick;
  logic                 found;
  logic [IDXW-1:0]      pick_idx;
  logic [IDXW-1:0]      pick_next;
  logic                 owner_rel;
  logic                 hold_expire;
  logic                 drop;
  logic                 new_grant;

  // Start wins over done; a warp finishing this cycle no longer competes.
  assign active_d  = (active_q & ~warp_done_i) | start_i;
  assign eligible  = issue_req_i & active_d;
  assign started_d = started_q | (|start_i);
  assign done_d    = started_d & (active_d == '0);

  rr_picker #(
    .N    (NUM_WARPS),
    .IDXW (IDXW)
  ) u_picker (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick),
    .found_o (found)
  );

  always_comb begin
    pick_idx  = '0;
    pick_next = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (pick[w]) begin
        pick_idx  = IDXW'(w);
        pick_next = IDXW'((w + 1) % NUM_WARPS);
      end
    end
  end

  // rr_ptr already points past the owner, so the owner's own re-request
  // naturally ends up last in the search order on release.
  assign owner_rel   = |(grant_q & (release_i | warp_done_i));
  assign hold_expire = (state_q == ARB_GRANTED) && (hold_cnt_q == HCW'(MAX_HOLD - 1));
  assign drop        = (state_q == ARB_GRANTED) && (owner_rel || hold_expire);
  assign new_grant   = found && ((state_q == ARB_IDLE) || drop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ARB_IDLE;
      active_q   <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      hold_cnt_q <= '0;
      hold_err_q <= 1'b0;
      started_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      hold_cnt_q <= hold_cnt_d;
      hold_err_q <= hold_err_d;
      started_q  <= started_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (found) state_d = ARB_GRANTED;
      end
      ARB_GRANTED: begin
        if (drop && !found) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    sel_d      = sel_q;
    hold_cnt_d = hold_cnt_q;
    hold_err_d = hold_err_q | (hold_expire && !owner_rel);
    if (new_grant) begin
      grant_d    = pick;
      rr_ptr_d   = pick_next;
      sel_d      = pick_idx;
      hold_cnt_d = '0;
    end else if (drop) begin
      grant_d    = '0;
      hold_cnt_d = '0;
    end else if (state_q == ARB_GRANTED) begin
      hold_cnt_d = hold_cnt_q + HCW'(1);
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = |grant_q;
  assign warp_select_o = sel_q;
  assign done_o        = done_q;
  assign hold_error_o  = hold_err_q;

endmodule

// File: tb/tb_warp_arbiter.sv
// Scoreboard bench for warp_arbiter: expected grants are queued as stimulus
// is applied and popped after each clock edge.
module tb_warp_arbiter;

  localparam int NW = 2;
  localparam int MH = 64;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [NW-1:0] start_i, warp_done_i, issue_req_i, release_i;
  logic [NW-1:0] grant_o;
  logic          grant_valid_o;
  logic [0:0]    warp_select_o;
  logic          done_o, hold_error_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] exp_g;

  warp_arbiter #(.NUM_WARPS(NW), .MAX_HOLD(MH)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .warp_done_i   (warp_done_i),
    .issue_req_i   (issue_req_i),
    .release_i     (release_i),
    .grant_o       (grant_o),
    .grant_valid_o (grant_valid_o),
    .warp_select_o (warp_select_o),
    .done_o        (done_o),
    .hold_error_o  (hold_error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (reset_i === 1'b0) begin
      n_cmp++;
      if (($countones(grant_o) > 1) || (grant_valid_o !== (|grant_o))) begin
        n_err++;
        $display("FAIL onehot: grant=%b valid=%b", grant_o, grant_valid_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = '0; warp_done_i = '0; issue_req_i = '0; release_i = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({grant_o, grant_valid_o, warp_select_o, done_o, hold_error_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got grant=%b valid=%b sel=%0d done=%b herr=%b, want all 0",
               grant_o, grant_valid_o, warp_select_o, done_o, hold_error_o);
    end
  endtask

  task automatic test_basic();
    start_i = 2'b11;
    tick();
    start_i = '0;
    issue_req_i = 2'b11;
    exp_q.push_back(2'b01);
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g || warp_select_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_first: grant=%b sel=%0d, want grant=%b sel=0", grant_o, warp_select_o, exp_g);
    end
    issue_req_i = 2'b10;
    release_i = 2'b01;
    exp_q.push_back(2'b10);
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g || warp_select_o !== 1'b1) begin
      n_err++;
      $display("FAIL basic_handoff: grant=%b sel=%0d, want grant=%b sel=1", grant_o, warp_select_o, exp_g);
    end
    issue_req_i = '0;
    release_i = 2'b10;
    exp_q.push_back(2'b00);
    tick();
    release_i = '0;
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g || warp_select_o !== 1'b1) begin
      n_err++;
      $display("FAIL basic_idle: grant=%b sel=%0d, want grant=%b sel=1 (held)", grant_o, warp_select_o, exp_g);
    end
  endtask

  // Both warps request every cycle; each owner releases in its third cycle.
  task automatic test_back_to_back();
    int ptr;
    int owner;
    ptr = 0;
    issue_req_i = 2'b11;
    owner = ptr;
    ptr = (owner + 1) % NW;
    exp_q.push_back(NW'(1 << owner));
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g) begin
      n_err++;
      $display("FAIL rr_first: grant=%b want=%b", grant_o, exp_g);
    end
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 2; c++) begin
        exp_q.push_back(NW'(1 << owner));
        tick();
        exp_g = exp_q.pop_front();
        n_cmp++;
        if (grant_o !== exp_g) begin
          n_err++;
          $display("FAIL rr_hold k=%0d c=%0d: grant=%b want=%b", k, c, grant_o, exp_g);
        end
      end
      release_i = NW'(1 << owner);
      if (k == 7) begin
        issue_req_i = '0;
        exp_q.push_back('0);
      end else begin
        owner = ptr;
        ptr = (owner + 1) % NW;
        exp_q.push_back(NW'(1 << owner));
      end
      tick();
      release_i = '0;
      exp_g = exp_q.pop_front();
      n_cmp++;
      if (grant_o !== exp_g) begin
        n_err++;
        $display("FAIL rr_switch k=%0d: grant=%b want=%b", k, grant_o, exp_g);
      end
    end
  endtask

  task automatic test_inactive();
    do_reset();
    start_i = 2'b10;
    tick();
    start_i = '0;
    issue_req_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('0);
      tick();
      exp_g = exp_q.pop_front();
      n_cmp++;
      if (grant_o !== exp_g) begin
        n_err++;
        $display("FAIL inactive_ignored i=%0d: grant=%b want=%b", i, grant_o, exp_g);
      end
    end
    issue_req_i = 2'b11;
    exp_q.push_back(2'b10);
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g || warp_select_o !== 1'b1) begin
      n_err++;
      $display("FAIL inactive_w1: grant=%b sel=%0d want grant=%b sel=1", grant_o, warp_select_o, exp_g);
    end
    issue_req_i = 2'b01;
    release_i = 2'b10;
    exp_q.push_back('0);
    tick();
    release_i = '0;
    issue_req_i = '0;
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g) begin
      n_err++;
      $display("FAIL inactive_after_rel: grant=%b want=%b", grant_o, exp_g);
    end
  endtask

  task automatic test_hold_watchdog();
    do_reset();
    start_i = 2'b11;
    tick();
    start_i = '0;
    issue_req_i = 2'b11;
    exp_q.push_back(2'b01);
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g) begin
      n_err++;
      $display("FAIL hold_first: grant=%b want=%b", grant_o, exp_g);
    end
    for (int i = 1; i < MH; i++) begin
      exp_q.push_back(2'b01);
      tick();
      exp_g = exp_q.pop_front();
      n_cmp++;
      if (grant_o !== exp_g || hold_error_o !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle %0d: grant=%b herr=%b want grant=%b herr=0", i, grant_o, hold_error_o, exp_g);
      end
    end
    exp_q.push_back(2'b10);
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g || hold_error_o !== 1'b1) begin
      n_err++;
      $display("FAIL hold_force: grant=%b herr=%b want grant=%b herr=1", grant_o, hold_error_o, exp_g);
    end
    issue_req_i = '0;
    release_i = 2'b10;
    exp_q.push_back('0);
    tick();
    release_i = '0;
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g || hold_error_o !== 1'b1) begin
      n_err++;
      $display("FAIL hold_sticky: grant=%b herr=%b want grant=%b herr=1", grant_o, hold_error_o, exp_g);
    end
  endtask

  task automatic test_done();
    do_reset();
    start_i = 2'b11;
    tick();
    start_i = '0;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("FAIL done_after_start: got %b want 0", done_o);
    end
    warp_done_i = 2'b01;
    tick();
    warp_done_i = '0;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("FAIL done_one_left: got %b want 0", done_o);
    end
    warp_done_i = 2'b10;
    tick();
    warp_done_i = '0;
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL done_rise: got %b want 1", done_o);
    end
    tick();
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL done_stays: got %b want 1", done_o);
    end
    start_i = 2'b01;
    tick();
    start_i = '0;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("FAIL done_restart: got %b want 0", done_o);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    start_i = 2'b11;
    tick();
    start_i = '0;
    issue_req_i = 2'b10;
    exp_q.push_back(2'b10);
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g) begin
      n_err++;
      $display("FAIL midrst_grant: grant=%b want=%b", grant_o, exp_g);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_cmp++;
    if ({grant_o, grant_valid_o, warp_select_o, done_o, hold_error_o} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: grant=%b valid=%b sel=%0d done=%b herr=%b want all 0",
               grant_o, grant_valid_o, warp_select_o, done_o, hold_error_o);
    end
    issue_req_i = 2'b11;
    exp_q.push_back('0);
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g) begin
      n_err++;
      $display("FAIL midrst_inactive: grant=%b want=%b", grant_o, exp_g);
    end
    issue_req_i = '0;
    start_i = 2'b11;
    tick();
    start_i = '0;
    issue_req_i = 2'b11;
    exp_q.push_back(2'b01);
    tick();
    exp_g = exp_q.pop_front();
    n_cmp++;
    if (grant_o !== exp_g || warp_select_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_regrant: grant=%b sel=%0d want grant=%b sel=0", grant_o, warp_select_o, exp_g);
    end
    issue_req_i = '0;
  endtask

  initial begin
    reset_i = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_inactive();
    test_hold_watchdog();
    test_done();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
